// File: rtl/sram_arbiter.sv
// Fetch/data arbiter onto a single asynchronous SRAM.
// Data has fixed priority; one transfer is IDLE, WAIT_CYCLES x ACCESS, DONE.
module sram_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [31:0]       inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_ack,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [3:0]        data_be,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_own_data;
    logic              r_rd;
    logic [31:0]       r_inst_rdata;
    logic [31:0]       r_data_rdata;
    logic              r_inst_ack;
    logic              r_data_ack;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic [3:0]        r_be_n;

    logic              w_req_any;
    logic              w_store;
    logic [31:0]       w_addr;
    logic              w_unused;

    assign w_req_any = data_req | inst_req;
    assign w_store   = data_req & data_we;
    assign w_addr    = data_req ? data_addr : inst_addr;
    assign w_unused  = ^{w_addr[31:ADDR_W+2], w_addr[1:0]};

    assign inst_rdata = r_inst_rdata;
    assign data_rdata = r_data_rdata;
    assign inst_ack   = r_inst_ack;
    assign data_ack   = r_data_ack;
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign sram_ce_n  = r_ce_n;
    assign sram_oe_n  = r_oe_n;
    assign sram_we_n  = r_we_n;
    assign sram_be_n  = r_be_n;

    // Transfer FSM: grant in IDLE, drive strobes in ACCESS, ack in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_own_data   <= 1'b0;
            r_rd         <= 1'b0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
            r_inst_ack   <= 1'b0;
            r_data_ack   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_be_n       <= 4'hF;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req_any) begin
                        r_state    <= ACCESS;
                        r_cnt      <= LAST_CNT;
                        r_own_data <= data_req;
                        r_rd       <= ~w_store;
                        r_addr     <= w_addr[ADDR_W+1:2];
                        r_ce_n     <= 1'b0;
                        if (w_store) begin
                            r_oe_n  <= 1'b1;
                            r_we_n  <= 1'b0;
                            r_be_n  <= ~data_be;
                            r_wdata <= data_wdata;
                        end else begin
                            r_oe_n <= 1'b0;
                            r_we_n <= 1'b1;
                            r_be_n <= 4'h0;
                        end
                    end
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= DONE;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_be_n  <= 4'hF;
                        if (r_own_data) begin
                            r_data_ack <= 1'b1;
                            if (r_rd) r_data_rdata <= sram_rdata;
                        end else begin
                            r_inst_ack <= 1'b1;
                            if (r_rd) r_inst_rdata <= sram_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_inst_ack <= 1'b0;
                    r_data_ack <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model plus expected-memory scoreboard.
// Extra instances with WAIT_CYCLES=1 and 15 check latency extremes.
module tb_sram_arbiter;

    localparam int W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] inst_rdata;
    logic        inst_ack;
    logic [31:0] data_rdata;
    logic        data_ack;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;

    int checks = 0;
    int errors = 0;

    sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata), .inst_ack(inst_ack),
        .data_req(data_req), .data_we(data_we), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_ack(data_ack),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_be_n(sram_be_n)
    );

    // Latency-extreme instances: fetch only, fixed SRAM read data.
    logic        req1, req15;
    logic        dreq_off;
    logic [31:0] fixed_rd;
    logic [31:0] rd1, rd15;
    logic        ack1, ack15;
    logic [31:0] unused1_drd, unused15_drd;
    logic        unused1_dack, unused15_dack;
    logic [19:0] unused1_addr, unused15_addr;
    logic [31:0] unused1_wd, unused15_wd;
    logic        unused1_ce, unused1_oe, unused1_we;
    logic        unused15_ce, unused15_oe, unused15_we;
    logic [3:0]  unused1_be, unused15_be;

    sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .inst_req(req1), .inst_addr(inst_addr),
        .inst_rdata(rd1), .inst_ack(ack1),
        .data_req(dreq_off), .data_we(data_we), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(unused1_drd), .data_ack(unused1_dack),
        .sram_addr(unused1_addr), .sram_wdata(unused1_wd),
        .sram_rdata(fixed_rd), .sram_ce_n(unused1_ce),
        .sram_oe_n(unused1_oe), .sram_we_n(unused1_we),
        .sram_be_n(unused1_be)
    );

    sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(15)) dut15 (
        .clk(clk), .rst(rst),
        .inst_req(req15), .inst_addr(inst_addr),
        .inst_rdata(rd15), .inst_ack(ack15),
        .data_req(dreq_off), .data_we(data_we), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(unused15_drd), .data_ack(unused15_dack),
        .sram_addr(unused15_addr), .sram_wdata(unused15_wd),
        .sram_rdata(fixed_rd), .sram_ce_n(unused15_ce),
        .sram_oe_n(unused15_oe), .sram_we_n(unused15_we),
        .sram_be_n(unused15_be)
    );

    // SRAM model: 256 words, word index from sram_addr[7:0].
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        preload;
    logic [31:0] wr_word;

    function automatic logic [31:0] seed_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ?
                        mem[sram_addr[7:0]] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed_word(i);
        end else if (!sram_ce_n && !sram_we_n) begin
            wr_word = mem[sram_addr[7:0]];
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) wr_word[8*b +: 8] = sram_wdata[8*b +: 8];
            mem[sram_addr[7:0]] <= wr_word;
        end
    end

    // Last read value the bench expects on each port.
    logic [31:0] exp_irdata;
    logic [31:0] exp_drdata;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr(input logic [7:0] word);
        logic [31:0] a;
        a = $urandom;
        a[21:10] = '0;
        a[9:2] = word;
        return a;
    endfunction

    // One transfer on the main DUT; inputs scrambled after the grant.
    // Latency counts edges from assertion, grant edge being edge 1.
    task automatic xfer(input bit is_data, input bit we,
                        input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
        logic [7:0]  w;
        logic [31:0] exp_rd;
        logic [3:0]  exp_ben;
        int          k;
        int          acc;
        bit          seen;
        bit          ok;
        bit          st;
        w = addr[9:2];
        st = is_data && we;
        exp_rd = ref_mem[w];
        exp_ben = st ? ~be : 4'h0;
        if (is_data) begin
            data_req = 1'b1; data_we = we; data_be = be;
            data_addr = addr; data_wdata = wdata;
        end else begin
            inst_req = 1'b1; inst_addr = addr;
        end
        k = 0; acc = 0; seen = 0; ok = 1;
        while (!seen && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) begin
                data_we = 1'($urandom); data_be = 4'($urandom);
                data_addr = $urandom; data_wdata = $urandom;
                inst_addr = $urandom;
            end
            if (!sram_ce_n) begin
                acc++;
                if (sram_addr !== 20'(w) || sram_oe_n !== st ||
                    sram_we_n !== !st || sram_be_n !== exp_ben) ok = 0;
                if (st && sram_wdata !== wdata) ok = 0;
            end else if (!(sram_oe_n && sram_we_n && sram_be_n == 4'hF)) begin
                ok = 0;
            end
            if (is_data ? data_ack : inst_ack) seen = 1;
            if (is_data ? inst_ack : data_ack) ok = 0;
        end
        data_req = 1'b0;
        inst_req = 1'b0;
        checks++;
        if (!seen || k !== W + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, k, W + 1);
        end
        checks++;
        if (acc !== W || !ok) begin
            errors++;
            $display("FAIL %s strobes: access cycles %0d want %0d ok=%0d",
                     tag, acc, W, ok);
        end
        if (st) ref_mem[w] = merge(ref_mem[w], wdata, be);
        else if (is_data) exp_drdata = exp_rd;
        else exp_irdata = exp_rd;
        checks++;
        if (data_rdata !== exp_drdata || inst_rdata !== exp_irdata) begin
            errors++;
            $display("FAIL %s rdata: inst %h data %h want inst %h data %h",
                     tag, inst_rdata, data_rdata, exp_irdata, exp_drdata);
        end
        @(posedge clk); #1;
        checks++;
        if (inst_ack !== 1'b0 || data_ack !== 1'b0) begin
            errors++;
            $display("FAIL %s ack_pulse: inst %b data %b want 0 0",
                     tag, inst_ack, data_ack);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (inst_ack !== 1'b0 || data_ack !== 1'b0 ||
            inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
            errors++;
            $display("FAIL %s acks/rdata: %b %b %h %h want 0 0 0 0",
                     tag, inst_ack, data_ack, inst_rdata, data_rdata);
        end
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 7'h7F) begin
            errors++;
            $display("FAIL %s strobes: %b want 1111111", tag,
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n});
        end
        checks++;
        if (sram_addr !== 20'h0 || sram_wdata !== 32'h0) begin
            errors++;
            $display("FAIL %s addr/wdata: %h %h want 0 0",
                     tag, sram_addr, sram_wdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; preload = 1'b1;
        inst_req = 0; inst_addr = 0; data_req = 0; data_we = 0;
        data_be = 0; data_addr = 0; data_wdata = 0;
        req1 = 0; req15 = 0; dreq_off = 0; fixed_rd = 32'h5A5A1234;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
        exp_irdata = 0; exp_drdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        preload = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_fetch();
        xfer(0, 0, 4'h0, 32'h00000010, 32'h0, "fetch_w4");
        xfer(1, 0, 4'h0, 32'hFFC00013, 32'h0, "load_hi_bits");
    endtask

    task automatic test_store();
        xfer(1, 1, 4'b0011, 32'h00000008, 32'hDEADBEEF, "store_be3");
        xfer(1, 0, 4'h0, 32'h00000008, 32'h0, "load_back_w2");
        xfer(1, 1, 4'b0000, 32'h0000000C, 32'h12345678, "store_be0");
        xfer(0, 0, 4'h0, 32'h0000000C, 32'h0, "fetch_back_w3");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            xfer(kind != 0, kind == 2, 4'($urandom),
                 rand_addr(8'($urandom_range(0, 31))), $urandom, "random");
        end
    endtask

    task automatic test_simultaneous();
        int k, td, ti;
        bit overlap;
        data_req = 1; data_we = 0; data_be = 0;
        data_addr = 32'h00000040; inst_req = 1; inst_addr = 32'h00000044;
        k = 0; td = 0; ti = 0; overlap = 0;
        while ((td == 0 || ti == 0) && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (inst_ack && data_ack) overlap = 1;
            if (data_ack) begin td = k; data_req = 0; end
            if (inst_ack) begin ti = k; inst_req = 0; end
        end
        data_req = 0; inst_req = 0;
        checks++;
        if (td !== W + 1 || ti - td !== W + 2 || overlap) begin
            errors++;
            $display("FAIL simul order: data@%0d inst@%0d ovl=%0d want %0d %0d 0",
                     td, ti, overlap, W + 1, 2 * W + 3);
        end
        exp_drdata = ref_mem[16];
        exp_irdata = ref_mem[17];
        checks++;
        if (data_rdata !== exp_drdata || inst_rdata !== exp_irdata) begin
            errors++;
            $display("FAIL simul rdata: %h %h want %h %h",
                     data_rdata, inst_rdata, exp_drdata, exp_irdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int k, n, last;
        bit ok;
        logic [7:0] words [5];
        for (int i = 0; i < 5; i++) words[i] = 8'(32 + 3 * i);
        inst_req = 1; inst_addr = rand_addr(words[0]);
        k = 0; n = 0; last = 0; ok = 1;
        while (n < 5 && k < 60) begin
            @(posedge clk); #1;
            k++;
            if (!sram_ce_n && sram_addr !== 20'(words[n])) ok = 0;
            if (data_ack) ok = 0;
            if (inst_ack) begin
                if (inst_rdata !== ref_mem[words[n]]) ok = 0;
                if (n == 0 ? k !== W + 1 : k - last !== W + 2) ok = 0;
                exp_irdata = ref_mem[words[n]];
                last = k;
                n++;
                if (n < 5) inst_addr = rand_addr(words[n]);
            end
        end
        inst_req = 0;
        checks++;
        if (n !== 5 || !ok) begin
            errors++;
            $display("FAIL back_to_back: acks %0d ok=%0d want 5 ok=1", n, ok);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_access();
        int k;
        bit acked;
        data_req = 1; data_we = 1; data_be = 4'hF;
        data_addr = 32'h0000001C; data_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        checks++;
        if (sram_ce_n !== 1'b0 || sram_we_n !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid started: ce_n %b we_n %b want 0 0",
                     sram_ce_n, sram_we_n);
        end
        #2 rst = 1'b0;
        #1;
        exp_irdata = 0; exp_drdata = 0;
        check_reset_outputs("rst_mid");
        data_req = 0;
        acked = 0;
        for (k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (inst_ack || data_ack) acked = 1;
        end
        checks++;
        if (acked) begin
            errors++;
            $display("FAIL rst_mid ack: got ack want none");
        end
        rst = 1'b1;
        xfer(0, 0, 4'h0, 32'h0000001C, 32'h0, "after_rst_fetch");
    endtask

    task automatic test_wait_extremes();
        int k, t1, t15;
        req1 = 1; req15 = 1; inst_addr = 32'h00000020;
        k = 0; t1 = 0; t15 = 0;
        while ((t1 == 0 || t15 == 0) && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (ack1 && t1 == 0) begin t1 = k; req1 = 0; end
            if (ack15 && t15 == 0) begin t15 = k; req15 = 0; end
        end
        req1 = 0; req15 = 0;
        checks++;
        if (t1 !== 2 || t15 !== 16) begin
            errors++;
            $display("FAIL wait_extremes latency: %0d %0d want 2 16", t1, t15);
        end
        checks++;
        if (rd1 !== fixed_rd || rd15 !== fixed_rd) begin
            errors++;
            $display("FAIL wait_extremes rdata: %h %h want %h",
                     rd1, rd15, fixed_rd);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_simultaneous();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        test_wait_extremes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
